// File: rtl/pipe_step_ctrl.sv
// Debug-run sequencer: drives the shared pipeline clock-enable from run/step/stop
// commands, drains the pipe after a HALT reaches decode, and counts enabled cycles.
module pipe_step_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_stop,
  input  logic             cmd_clear,
  input  logic             halt_id,
  output logic             db_ena,
  output logic             running,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]    DRAIN_LD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0]    DRAIN_ONE = DW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DRAIN, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic             halt_pend_q, halt_pend_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] cnt_d;
  logic             clr_cnt;

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    drain_cnt_d = drain_cnt_q;
    clr_cnt     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // stop outranks step, step outranks run
        if (!cmd_stop) begin
          if (cmd_step)     state_d = S_STEP;
          else if (cmd_run) state_d = halt_pend_q ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (halt_id && !halt_pend_q) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LD;
        end else if (cmd_stop) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
        if (halt_pend_q) begin
          drain_cnt_d = drain_cnt_q - DRAIN_ONE;
          if (drain_cnt_q == DRAIN_ONE) state_d = S_HALTED;
        end else if (halt_id) begin
          halt_pend_d = 1'b1;
          drain_cnt_d = DRAIN_LD;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_ONE;
        if (drain_cnt_q == DRAIN_ONE) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (cmd_clear) begin
          state_d     = S_IDLE;
          halt_pend_d = 1'b0;
          clr_cnt     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cycle_cnt;
    if (clr_cnt)                           cnt_d = '0;
    else if (db_ena && cycle_cnt != CNT_MAX) cnt_d = cycle_cnt + CNT_ONE;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      halt_pend_q <= 1'b0;
      drain_cnt_q <= '0;
      db_ena      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      step_done   <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      drain_cnt_q <= drain_cnt_d;
      db_ena      <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
      running     <= (state_d == S_RUN) || (state_d == S_DRAIN);
      halted      <= (state_d == S_HALTED);
      step_done   <= (state_q == S_STEP);
      cycle_cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Bench for pipe_step_ctrl: directed scenarios plus randomized run/step sessions
// whose expected enabled-cycle totals come from simple arithmetic on the command schedule.
module tb_pipe_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_run, cmd_step, cmd_stop, cmd_clear, halt_id;
  logic        db_ena, running, halted, step_done;
  logic [31:0] cycle_cnt;

  logic        s_reset, s_run, s_stop, s_zero;
  logic        s_db_ena, s_running, s_halted, s_step_done;
  logic [3:0]  s_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int mon_en   = 0;
  int mon_sd   = 0;

  pipe_step_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_step(cmd_step),
    .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .halt_id(halt_id),
    .db_ena(db_ena), .running(running), .halted(halted),
    .step_done(step_done), .cycle_cnt(cycle_cnt)
  );

  pipe_step_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(s_reset), .cmd_run(s_run), .cmd_step(s_zero),
    .cmd_stop(s_stop), .cmd_clear(s_zero), .halt_id(s_zero),
    .db_ena(s_db_ena), .running(s_running), .halted(s_halted),
    .step_done(s_step_done), .cycle_cnt(s_cnt)
  );

  always @(negedge clk) begin
    mon_en <= mon_en + (db_ena ? 1 : 0);
    mon_sd <= mon_sd + (step_done ? 1 : 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0; halt_id = 1'b0;
  endtask

  task automatic do_reset();
    clear_cmds();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    clear_cmds();
    reset = 1'b1; s_reset = 1'b1; s_run = 1'b0; s_stop = 1'b0; s_zero = 1'b0;
    repeat (2) cyc();
    n_checks++; if (db_ena !== 1'b0) $display("FAIL reset_db_ena: got %b want 0", db_ena); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (step_done !== 1'b0) $display("FAIL reset_step_done: got %b want 0", step_done); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd0) $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); else n_pass++;
    n_checks++; if ({s_db_ena, s_running, s_halted, s_step_done, s_cnt} !== 8'd0)
      $display("FAIL reset_sat_outputs: got %b want 00000000", {s_db_ena, s_running, s_halted, s_step_done, s_cnt}); else n_pass++;
    reset = 1'b0; s_reset = 1'b0;
    cyc();
  endtask

  task automatic test_step();
    int e0, s0;
    do_reset();
    e0 = mon_en; s0 = mon_sd;
    for (int i = 0; i < 3; i++) begin
      cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
      n_checks++; if (db_ena !== 1'b1) $display("FAIL step_ena[%0d]: got %b want 1", i, db_ena); else n_pass++;
      cyc();
      n_checks++; if ({db_ena, step_done} !== 2'b01) $display("FAIL step_done[%0d]: got ena/done %b want 01", i, {db_ena, step_done}); else n_pass++;
      repeat (4) cyc();
    end
    n_checks++; if (mon_en - e0 !== 3) $display("FAIL step_en_cycles: got %0d want 3", mon_en - e0); else n_pass++;
    n_checks++; if (mon_sd - s0 !== 3) $display("FAIL step_done_pulses: got %0d want 3", mon_sd - s0); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd3) $display("FAIL step_cycle_cnt: got %0d want 3", cycle_cnt); else n_pass++;
  endtask

  task automatic test_run_stop();
    int e0;
    do_reset();
    e0 = mon_en;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    n_checks++; if ({db_ena, running} !== 2'b11) $display("FAIL run_start: got ena/running %b want 11", {db_ena, running}); else n_pass++;
    repeat (9) cyc();
    cmd_stop = 1'b1; cyc(); cmd_stop = 1'b0;
    n_checks++; if (db_ena !== 1'b0) $display("FAIL stop_ena: got %b want 0", db_ena); else n_pass++;
    repeat (3) cyc();
    n_checks++; if (mon_en - e0 !== 10) $display("FAIL run_en_cycles: got %0d want 10", mon_en - e0); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd10) $display("FAIL run_cycle_cnt: got %0d want 10", cycle_cnt); else n_pass++;
    n_checks++; if ({running, halted} !== 2'b00) $display("FAIL run_idle_flags: got running/halted %b want 00", {running, halted}); else n_pass++;
  endtask

  task automatic test_halt_run();
    int e0, t;
    logic prev;
    do_reset();
    e0 = mon_en;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    repeat (6) cyc();
    halt_id = 1'b1; cyc(); halt_id = 0;
    n_checks++; if ({db_ena, running} !== 2'b11) $display("FAIL drain_flags: got ena/running %b want 11", {db_ena, running}); else n_pass++;
    t = 0; prev = db_ena;
    while (halted !== 1'b1 && t < 20) begin prev = db_ena; cyc(); t++; end
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_timeout: got halted %b want 1 within 20 cycles", halted); else n_pass++;
    n_checks++; if ({prev, db_ena, running} !== 3'b100) $display("FAIL halt_edge: got prev_ena/ena/running %b want 100", {prev, db_ena, running}); else n_pass++;
    cyc();
    n_checks++; if (mon_en - e0 !== 11) $display("FAIL halt_en_cycles: got %0d want 11", mon_en - e0); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd11) $display("FAIL halt_cycle_cnt: got %0d want 11", cycle_cnt); else n_pass++;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    cmd_stop = 1'b1; cyc(); cmd_stop = 1'b0;
    repeat (2) cyc();
    n_checks++; if ({halted, db_ena} !== 2'b10) $display("FAIL halted_ignore: got halted/ena %b want 10", {halted, db_ena}); else n_pass++;
    n_checks++; if (mon_en - e0 !== 11) $display("FAIL halted_no_advance: got %0d want 11", mon_en - e0); else n_pass++;
    cmd_clear = 1'b1; cyc(); cmd_clear = 1'b0;
    n_checks++; if ({halted, db_ena} !== 2'b00) $display("FAIL clear_flags: got halted/ena %b want 00", {halted, db_ena}); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd0) $display("FAIL clear_cycle_cnt: got %0d want 0", cycle_cnt); else n_pass++;
  endtask

  task automatic test_step_halt();
    int e0;
    do_reset();
    e0 = mon_en;
    for (int i = 1; i <= 6; i++) begin
      cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
      n_checks++; if (db_ena !== 1'b1) $display("FAIL shalt_ena[%0d]: got %b want 1", i, db_ena); else n_pass++;
      halt_id = (i == 2); cyc(); halt_id = 1'b0;
      n_checks++; if ({step_done, halted} !== {1'b1, i == 6}) $display("FAIL shalt_done_halted[%0d]: got %b want %b", i, {step_done, halted}, {1'b1, i == 6}); else n_pass++;
      repeat (2) cyc();
    end
    n_checks++; if (cycle_cnt !== 32'd6) $display("FAIL shalt_cycle_cnt: got %0d want 6", cycle_cnt); else n_pass++;
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    repeat (2) cyc();
    n_checks++; if (mon_en - e0 !== 6) $display("FAIL shalt_en_cycles: got %0d want 6", mon_en - e0); else n_pass++;
  endtask

  task automatic test_priority();
    int e0, s0;
    do_reset();
    e0 = mon_en; s0 = mon_sd;
    cmd_run = 1'b1; cmd_step = 1'b1; cyc(); clear_cmds();
    n_checks++; if ({db_ena, running} !== 2'b10) $display("FAIL prio_run_step: got ena/running %b want 10", {db_ena, running}); else n_pass++;
    repeat (3) cyc();
    n_checks++; if ((mon_en - e0) * 10 + (mon_sd - s0) !== 11) $display("FAIL prio_step_once: got en*10+done %0d want 11", (mon_en - e0) * 10 + (mon_sd - s0)); else n_pass++;
    e0 = mon_en;
    cmd_stop = 1'b1; cmd_step = 1'b1; cyc(); clear_cmds();
    repeat (2) cyc();
    cmd_stop = 1'b1; cmd_run = 1'b1; cyc(); clear_cmds();
    repeat (2) cyc();
    n_checks++; if (mon_en - e0 !== 0) $display("FAIL prio_stop_wins: got %0d enabled cycles want 0", mon_en - e0); else n_pass++;
  endtask

  task automatic test_saturate();
    s_reset = 1'b1; cyc(); s_reset = 1'b0; cyc();
    s_run = 1'b1; cyc(); s_run = 1'b0;
    repeat (14) cyc();
    n_checks++; if (s_cnt !== 4'd14) $display("FAIL sat_pre: got %0d want 14", s_cnt); else n_pass++;
    repeat (6) cyc();
    n_checks++; if ({s_db_ena, s_cnt} !== {1'b1, 4'd15}) $display("FAIL sat_hold: got ena/cnt %b want 11111", {s_db_ena, s_cnt}); else n_pass++;
    s_stop = 1'b1; cyc(); s_stop = 1'b0;
    n_checks++; if ({s_db_ena, s_running, s_cnt} !== {2'b00, 4'd15}) $display("FAIL sat_stop: got %b want 001111", {s_db_ena, s_running, s_cnt}); else n_pass++;
  endtask

  task automatic test_reset_drain();
    do_reset();
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    repeat (2) cyc();
    halt_id = 1'b1; cyc(); halt_id = 1'b0;
    cyc();
    n_checks++; if ({db_ena, running} !== 2'b11) $display("FAIL rd_in_drain: got %b want 11", {db_ena, running}); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({db_ena, running, halted, step_done} !== 4'b0000) $display("FAIL rd_async: got %b want 0000", {db_ena, running, halted, step_done}); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd0) $display("FAIL rd_cycle_cnt: got %0d want 0", cycle_cnt); else n_pass++;
    cyc(); reset = 1'b0;
    repeat (6) cyc();
    n_checks++; if ({db_ena, halted, step_done} !== 3'b000) $display("FAIL rd_no_resume: got %b want 000", {db_ena, halted, step_done}); else n_pass++;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    n_checks++; if ({db_ena, running} !== 2'b11) $display("FAIL rd_rerun: got %b want 11", {db_ena, running}); else n_pass++;
    cmd_stop = 1'b1; cyc(); cmd_stop = 1'b0;
  endtask

  task automatic test_random();
    int e0, s0, exp_en, n, h, len, k;
    bit do_halt, exp_halt;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      e0 = mon_en; s0 = mon_sd;
      if ($urandom_range(1, 0) == 1) begin
        len = $urandom_range(25, 2);
        do_halt = ($urandom_range(1, 0) == 1);
        k = $urandom_range(len, 1);
        cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
        for (int j = 1; j <= (do_halt ? k + 8 : len + 3); j++) begin
          if (do_halt) begin
            halt_id  = (j == k) || (j > k && j <= k + 4 && $urandom_range(1, 0) == 1);
            cmd_stop = (j > k) && ($urandom_range(1, 0) == 1);
            cmd_step = (j > k) && ($urandom_range(1, 0) == 1);
            cmd_run  = (j > k) && ($urandom_range(1, 0) == 1);
          end else begin
            cmd_stop = (j == len);
          end
          cyc(); clear_cmds();
        end
        exp_en = do_halt ? k + 4 : len;
        exp_halt = do_halt;
        repeat (2) cyc();
        n_checks++; if (mon_en - e0 !== exp_en) $display("FAIL rnd_run_en[%0d]: got %0d want %0d", it, mon_en - e0, exp_en); else n_pass++;
      end else begin
        n = $urandom_range(8, 1);
        h = $urandom_range(5, 0);
        for (int i = 1; i <= n; i++) begin
          cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
          halt_id = (h != 0) && (i == h || (i > h && i <= h + 4 && $urandom_range(1, 0) == 1));
          cyc(); halt_id = 1'b0;
          repeat ($urandom_range(3, 0)) cyc();
        end
        repeat (2) cyc();
        exp_en = (h != 0 && n > h + 4) ? h + 4 : n;
        exp_halt = (h != 0) && (n >= h + 4);
        n_checks++; if (mon_sd - s0 !== exp_en) $display("FAIL rnd_step_done[%0d]: got %0d want %0d", it, mon_sd - s0, exp_en); else n_pass++;
        n_checks++; if (mon_en - e0 !== exp_en) $display("FAIL rnd_step_en[%0d]: got %0d want %0d", it, mon_en - e0, exp_en); else n_pass++;
      end
      n_checks++; if (cycle_cnt !== 32'(exp_en)) $display("FAIL rnd_cycle_cnt[%0d]: got %0d want %0d", it, cycle_cnt, exp_en); else n_pass++;
      n_checks++; if ({halted, running, db_ena} !== {exp_halt, 2'b00}) $display("FAIL rnd_flags[%0d]: got %b want %b", it, {halted, running, db_ena}, {exp_halt, 2'b00}); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_stop();
    test_halt_run();
    test_step_halt();
    test_priority();
    test_saturate();
    test_reset_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
